// File: rtl/dm_access_unit.sv
// Memory-stage load/store initiator: byte/half/word accesses over a word-wide data port,
// with read-modify-write for sub-word stores. Define DM_ACCESS_TRACE_EN to log every memory write.

module dm_byte_lane (
  input  logic       sel,
  input  logic [7:0] old_b,
  input  logic [7:0] new_b,
  output logic [7:0] out_b
);
  assign out_b = sel ? new_b : old_b;
endmodule

module dm_access_unit #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid_M,
  input  logic              req_write_M,
  input  logic [1:0]        req_size_M,
  input  logic              req_signed_M,
  input  logic [ADDR_W-1:0] req_addr_M,
  input  logic [31:0]       req_wdata_M,
  input  logic [31:0]       req_pc_M,
  output logic              stall_M,
  output logic              done_M,
  output logic              misalign_M,
  output logic [31:0]       load_data_M,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);
  localparam int NUM_LANES = 4;

  typedef enum logic [2:0] {IDLE, LOAD, RMW_RD, WRITE, RESP} state_t;

  state_t            state, state_nx;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [1:0]        size_q;
  logic              signed_q;
  logic              write_q;
  logic [31:0]       pc_q;
  logic              mis_q;
  logic [31:0]       load_data_q;

  logic              req_mis;
  logic [NUM_LANES-1:0]      lane_sel;
  logic [NUM_LANES-1:0][7:0] st_aligned;
  logic [NUM_LANES-1:0][7:0] rd_lanes;
  logic [NUM_LANES-1:0][7:0] merged;
  logic [31:0]       rd_shift;
  logic [31:0]       ld_ext;

  // Size 2'b11 behaves as a word everywhere, so size[1] alone marks a word.
  assign req_mis = (req_size_M == 2'b01 && req_addr_M[0]) ||
                   (req_size_M[1] && req_addr_M[1:0] != 2'b00);

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (req_valid_M) begin
          if (req_mis)             state_nx = RESP;
          else if (!req_write_M)   state_nx = LOAD;
          else if (req_size_M[1])  state_nx = WRITE;
          else                     state_nx = RMW_RD;
        end
      end
      LOAD:    state_nx = RESP;
      RMW_RD:  state_nx = WRITE;
      WRITE:   state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // ---------------- lane logic ----------------
  always_comb begin
    lane_sel = '0;
    case (size_q)
      2'b00:   lane_sel[addr_q[1:0]] = 1'b1;
      2'b01:   lane_sel = addr_q[1] ? 4'b1100 : 4'b0011;
      default: lane_sel = 4'b1111;
    endcase
  end

  // Replicate store data across lanes; lane_sel picks which copy lands.
  always_comb begin
    st_aligned = '0;
    case (size_q)
      2'b00:   st_aligned = {NUM_LANES{wdata_q[7:0]}};
      2'b01:   st_aligned = {2{wdata_q[15:0]}};
      default: st_aligned = wdata_q;
    endcase
  end

  assign rd_lanes = mem_rdata;

  genvar g;
  generate
    for (g = 0; g < NUM_LANES; g++) begin : g_lane
      dm_byte_lane u_lane (
        .sel   (lane_sel[g]),
        .old_b (rd_lanes[g]),
        .new_b (st_aligned[g]),
        .out_b (merged[g])
      );
    end
  endgenerate

  // Load path: shift the addressed lane down to bit 0, then extend.
  assign rd_shift = mem_rdata >> {addr_q[1:0], 3'b000};

  always_comb begin
    ld_ext = mem_rdata;
    case (size_q)
      2'b00:   ld_ext = {{24{signed_q & rd_shift[7]}},  rd_shift[7:0]};
      2'b01:   ld_ext = {{16{signed_q & rd_shift[15]}}, rd_shift[15:0]};
      default: ld_ext = mem_rdata;
    endcase
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q      <= '0;
      wdata_q     <= '0;
      size_q      <= '0;
      signed_q    <= 1'b0;
      write_q     <= 1'b0;
      pc_q        <= '0;
      mis_q       <= 1'b0;
      load_data_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid_M) begin
            addr_q      <= req_addr_M;
            wdata_q     <= req_wdata_M;
            size_q      <= req_size_M;
            signed_q    <= req_signed_M;
            write_q     <= req_write_M;
            pc_q        <= req_pc_M;
            mis_q       <= req_mis;
            load_data_q <= '0;
          end
        end
        LOAD:    load_data_q <= ld_ext;
        RMW_RD:  wdata_q     <= merged;
        default: ;
      endcase
    end
  end

  // ---------------- outputs ----------------
  assign stall_M     = req_valid_M && (state != RESP);
  assign done_M      = (state == RESP);
  assign misalign_M  = (state == RESP) && mis_q;
  assign load_data_M = load_data_q;
  assign mem_we      = (state == WRITE);
  assign mem_addr    = {addr_q[ADDR_W-1:2], 2'b00};
  assign mem_wdata   = wdata_q;

  // write_q and pc_q are kept for trace/debug visibility only.
  logic unused_q;
  assign unused_q = ^{write_q, pc_q};

`ifdef DM_ACCESS_TRACE_EN
  always @(posedge clk) begin
    if (reset && state == WRITE)
      $display("%d@%h: *%h <= %h", $time, pc_q, mem_addr, mem_wdata);
  end
`else
  // Trace disabled: no simulation output.
`endif

endmodule

// File: tb/tb_dm_access_unit.sv
// Scoreboard bench for dm_access_unit: driver pushes expected writes/responses,
// a negedge monitor pops and compares them as the DUT presents mem_we / done_M.

module tb_dm_access_unit;
  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid_M, req_write_M, req_signed_M;
  logic [1:0]  req_size_M;
  logic [31:0] req_addr_M, req_wdata_M, req_pc_M;
  logic        stall_M, done_M, misalign_M, mem_we;
  logic [31:0] load_data_M, mem_addr, mem_wdata, mem_rdata;

  logic [31:0] mem [0:1023];

  typedef struct {logic [31:0] addr; logic [31:0] data; string nm;} wr_t;
  typedef struct {logic mis; logic chk_ld; logic [31:0] ld; string nm;} resp_t;
  wr_t   wq[$];
  resp_t rq[$];

  int npass = 0;
  int ntot  = 0;

  always #5 clk = ~clk;

  dm_access_unit #(.ADDR_W(32)) dut (
    .clk(clk), .reset(reset),
    .req_valid_M(req_valid_M), .req_write_M(req_write_M), .req_size_M(req_size_M),
    .req_signed_M(req_signed_M), .req_addr_M(req_addr_M), .req_wdata_M(req_wdata_M),
    .req_pc_M(req_pc_M), .stall_M(stall_M), .done_M(done_M), .misalign_M(misalign_M),
    .load_data_M(load_data_M), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  assign mem_rdata = mem[mem_addr[11:2]];
  always @(posedge clk) if (mem_we) mem[mem_addr[11:2]] <= mem_wdata;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Monitor: compare whatever the DUT presents against the queued expectations.
  always @(negedge clk) begin
    if (mem_we) begin
      if (wq.size() == 0) begin
        ntot++;
        $display("FAIL unexpected_we: got write %h to %h expected none", mem_wdata, mem_addr);
      end else begin
        wr_t w;
        w = wq.pop_front();
        check({w.nm, "_waddr"}, mem_addr, w.addr);
        check({w.nm, "_wdata"}, mem_wdata, w.data);
      end
    end
    if (done_M) begin
      if (rq.size() == 0) begin
        ntot++;
        $display("FAIL unexpected_done: got done_M expected none");
      end else begin
        resp_t r;
        r = rq.pop_front();
        check({r.nm, "_mis"}, {31'b0, misalign_M}, {31'b0, r.mis});
        if (r.chk_ld) check({r.nm, "_ld"}, load_data_M, r.ld);
      end
    end
  end

  task automatic set_req(input logic wr, input logic [1:0] sz, input logic sg,
                         input logic [31:0] addr, input logic [31:0] wd);
    req_valid_M  = 1'b1;
    req_write_M  = wr;
    req_size_M   = sz;
    req_signed_M = sg;
    req_addr_M   = addr;
    req_wdata_M  = wd;
    req_pc_M     = 32'h1000 + addr;
  endtask

  // Called at posedge+1 with the DUT in IDLE (cycle 0). exp_val is the load result
  // for loads, or the full word expected on mem_wdata for aligned stores.
  task automatic do_req(input string nm, input logic wr, input logic [1:0] sz, input logic sg,
                        input logic [31:0] addr, input logic [31:0] wd, input int lat,
                        input logic mis, input logic [31:0] exp_val);
    resp_t r;
    r.nm = nm; r.mis = mis; r.chk_ld = !wr || mis; r.ld = mis ? 32'h0 : exp_val;
    rq.push_back(r);
    if (wr && !mis) begin
      wr_t w;
      w.nm = nm; w.addr = {addr[31:2], 2'b00}; w.data = exp_val;
      wq.push_back(w);
    end
    set_req(wr, sz, sg, addr, wd);
    #1;
    check({nm, "_stall_c0"}, {31'b0, stall_M}, 32'd1);
    for (int cyc = 1; cyc <= lat; cyc++) begin
      @(posedge clk); #1;
      check({nm, "_done_c", $sformatf("%0d", cyc)}, {31'b0, done_M}, {31'b0, cyc == lat});
      check({nm, "_stall_c", $sformatf("%0d", cyc)}, {31'b0, stall_M}, {31'b0, cyc != lat});
      check({nm, "_we_c", $sformatf("%0d", cyc)}, {31'b0, mem_we},
            {31'b0, wr && !mis && cyc == lat - 1});
    end
    req_valid_M = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic check_zero_outs(input string nm);
    check({nm, "_we"},   {31'b0, mem_we},     32'd0);
    check({nm, "_done"}, {31'b0, done_M},     32'd0);
    check({nm, "_mis"},  {31'b0, misalign_M}, 32'd0);
    check({nm, "_ld"},   load_data_M,         32'd0);
    check({nm, "_addr"}, mem_addr,            32'd0);
    check({nm, "_wd"},   mem_wdata,           32'd0);
  endtask

  initial begin
    reset = 1'b0;
    req_valid_M = 1'b0; req_write_M = 1'b0; req_size_M = 2'b00; req_signed_M = 1'b0;
    req_addr_M = '0; req_wdata_M = '0; req_pc_M = '0;
    repeat (2) @(posedge clk);
    #1;
    check_zero_outs("rst");
    check("rst_stall_lo", {31'b0, stall_M}, 32'd0);
    set_req(1'b1, 2'b10, 1'b0, 32'h40, 32'h12345678);
    #1;
    check("rst_stall_hi", {31'b0, stall_M}, 32'd1);
    req_valid_M = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;

    // name              wr    size   sg    addr    wdata         lat mis  expected
    do_req("sw_pre1", 1'b1, 2'b10, 1'b0, 32'h10, 32'h80223344, 2, 1'b0, 32'h80223344);
    do_req("lb_13",   1'b0, 2'b00, 1'b1, 32'h13, 32'h0,        2, 1'b0, 32'hFFFFFF80);
    do_req("lbu_13",  1'b0, 2'b00, 1'b0, 32'h13, 32'h0,        2, 1'b0, 32'h00000080);
    do_req("sw_pre2", 1'b1, 2'b10, 1'b0, 32'h10, 32'h11228000, 2, 1'b0, 32'h11228000);
    do_req("lh_10",   1'b0, 2'b01, 1'b1, 32'h10, 32'h0,        2, 1'b0, 32'hFFFF8000);
    do_req("lhu_12",  1'b0, 2'b01, 1'b0, 32'h12, 32'h0,        2, 1'b0, 32'h00001122);
    do_req("sw_pre3", 1'b1, 2'b10, 1'b0, 32'h10, 32'h11223344, 2, 1'b0, 32'h11223344);
    do_req("sb_11",   1'b1, 2'b00, 1'b0, 32'h11, 32'h000000AB, 3, 1'b0, 32'h1122AB44);
    do_req("lw_10a",  1'b0, 2'b10, 1'b0, 32'h10, 32'h0,        2, 1'b0, 32'h1122AB44);
    do_req("sh_12",   1'b1, 2'b01, 1'b0, 32'h12, 32'h5555CAFE, 3, 1'b0, 32'hCAFEAB44);
    do_req("lb_12",   1'b0, 2'b00, 1'b1, 32'h12, 32'h0,        2, 1'b0, 32'hFFFFFFFE);
    do_req("lbu_10",  1'b0, 2'b00, 1'b0, 32'h10, 32'h0,        2, 1'b0, 32'h00000044);
    do_req("sw_20",   1'b1, 2'b10, 1'b0, 32'h20, 32'hDEADBEEF, 2, 1'b0, 32'hDEADBEEF);
    do_req("lw_20",   1'b0, 2'b10, 1'b0, 32'h20, 32'h0,        2, 1'b0, 32'hDEADBEEF);
    do_req("l11_20",  1'b0, 2'b11, 1'b1, 32'h20, 32'h0,        2, 1'b0, 32'hDEADBEEF);
    do_req("sh_mis",  1'b1, 2'b01, 1'b0, 32'h13, 32'h0000BEEF, 1, 1'b1, 32'h0);
    do_req("sw_mis",  1'b1, 2'b10, 1'b0, 32'h22, 32'hCAFEF00D, 1, 1'b1, 32'h0);
    do_req("lh_mis",  1'b0, 2'b01, 1'b1, 32'h11, 32'h0,        1, 1'b1, 32'h0);
    do_req("lw_20b",  1'b0, 2'b10, 1'b0, 32'h20, 32'h0,        2, 1'b0, 32'hDEADBEEF);

    // Reset abort in RMW_RD, release with the request dropped: memory must be untouched.
    do_req("sw_pre4", 1'b1, 2'b10, 1'b0, 32'h10, 32'h11223344, 2, 1'b0, 32'h11223344);
    set_req(1'b1, 2'b00, 1'b0, 32'h11, 32'h000000AB);
    @(posedge clk); #1;
    check("ab1_stall_rmw", {31'b0, stall_M}, 32'd1);
    reset = 1'b0;
    #1;
    check_zero_outs("ab1");
    check("ab1_stall", {31'b0, stall_M}, 32'd1);
    @(posedge clk); #1;
    check("ab1_we_held", {31'b0, mem_we}, 32'd0);
    req_valid_M = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    do_req("lw_ab1",  1'b0, 2'b10, 1'b0, 32'h10, 32'h0,        2, 1'b0, 32'h11223344);

    // Reset abort, release with the request held: full store runs again from IDLE.
    set_req(1'b1, 2'b00, 1'b0, 32'h11, 32'h000000AB);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    check_zero_outs("ab2");
    @(posedge clk); #1;
    reset = 1'b1;
    do_req("sb_ab2",  1'b1, 2'b00, 1'b0, 32'h11, 32'h000000AB, 3, 1'b0, 32'h1122AB44);
    do_req("lw_ab2",  1'b0, 2'b10, 1'b0, 32'h10, 32'h0,        2, 1'b0, 32'h1122AB44);

    repeat (3) @(posedge clk);
    #1;
    check("wq_drained", wq.size(), 32'd0);
    check("rq_drained", rq.size(), 32'd0);
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish before 200000");
    $fatal(1);
  end
endmodule
